// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int unsigned PC_STEP   = 32'd4;

  function automatic logic is_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: redirect/stall inputs, instruction memory port and IF/ID register.
// FetchMisalign exists only when FETCH_MISALIGN_CHK_EN is defined.
interface fetch_unit_if #(
  parameter int PC_W    = 9,
  parameter int INSTR_W = 32
) ();

  logic               Stall;
  logic               PcSel;
  logic [31:0]        BrPC;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [PC_W-1:0]    IfId_PC;
  logic [INSTR_W-1:0] IfId_Instr;
  logic               IfId_Valid;
  logic               Flush;
`ifdef FETCH_MISALIGN_CHK_EN
  logic               FetchMisalign;
`endif

  modport master (
    input  Stall, input PcSel, input BrPC, input imem_rdata,
    output imem_addr, output IfId_PC, output IfId_Instr, output IfId_Valid, output Flush
`ifdef FETCH_MISALIGN_CHK_EN
    , output FetchMisalign
`endif
  );

  modport slave (
    output Stall, output PcSel, output BrPC, output imem_rdata,
    input  imem_addr, input IfId_PC, input IfId_Instr, input IfId_Valid, input Flush
`ifdef FETCH_MISALIGN_CHK_EN
    , input FetchMisalign
`endif
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry hold buffer: captures the memory word that arrives while the pipe is stalled.
module fetch_hold_buf #(
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               capture,
  input  logic               flush,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic               d_vld,
  output logic [INSTR_W-1:0] q_instr,
  output logic               q_vld
);

  logic [INSTR_W-1:0] instr_r;
  logic               vld_r;

  // Capture register; flush drops the entry so a redirect never replays it.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_r <= {INSTR_W{1'b0}};
      vld_r   <= 1'b0;
    end else if (flush) begin
      vld_r   <= 1'b0;
    end else if (capture) begin
      instr_r <= d_instr;
      vld_r   <= d_vld;
    end
  end

  assign q_instr = instr_r;
  assign q_vld   = vld_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC ownership, stall hold buffer, redirect/flush, IF/ID register.
// Optional misaligned-target trap is enabled by defining FETCH_MISALIGN_CHK_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W    = 9,
  parameter int INSTR_W = 32
) (
  input logic        clk,
  input logic        reset,
  fetch_unit_if.master bus
);

  localparam logic [PC_W-1:0]    STEP = PC_W'(PC_STEP);
  localparam logic [INSTR_W-1:0] NOP  = INSTR_W'(NOP_INSTR);

  fetch_state_e       state_r, state_s;
  logic [PC_W-1:0]    fetch_pc_r, fetch_pc_s;
  logic [PC_W-1:0]    req_pc_r, req_pc_s;
  logic               req_vld_r, req_vld_s;
  logic [PC_W-1:0]    ifid_pc_r, ifid_pc_s;
  logic [INSTR_W-1:0] ifid_instr_r, ifid_instr_s;
  logic               ifid_vld_r, ifid_vld_s;
  logic               buf_capture_s, buf_flush_s;
  logic [INSTR_W-1:0] buf_instr_s;
  logic               buf_vld_s;
  logic [PC_W-1:0]    target_s;
  logic               unused_brpc_s;
`ifdef FETCH_MISALIGN_CHK_EN
  logic               misalign_r, misalign_s;

  assign target_s = bus.BrPC[PC_W-1:0];
`else
  assign target_s = {bus.BrPC[PC_W-1:2], 2'b00};
`endif
  assign unused_brpc_s = ^{bus.BrPC[31:PC_W], bus.BrPC[1:0]};

  fetch_hold_buf #(.INSTR_W(INSTR_W)) u_hold_buf (
    .clk     (clk),
    .reset   (reset),
    .capture (buf_capture_s),
    .flush   (buf_flush_s),
    .d_instr (bus.imem_rdata),
    .d_vld   (req_vld_r),
    .q_instr (buf_instr_s),
    .q_vld   (buf_vld_s)
  );

  // Next-state and datapath control; halt beats redirect, redirect beats stall.
  always_comb begin
    state_s       = state_r;
    fetch_pc_s    = fetch_pc_r;
    req_pc_s      = req_pc_r;
    req_vld_s     = req_vld_r;
    ifid_pc_s     = ifid_pc_r;
    ifid_instr_s  = ifid_instr_r;
    ifid_vld_s    = ifid_vld_r;
    buf_capture_s = 1'b0;
    buf_flush_s   = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    misalign_s    = misalign_r;
`endif
    if (state_r == S_HALT) begin
      ifid_vld_s   = 1'b0;
      ifid_instr_s = NOP;
    end else if (bus.PcSel) begin
      buf_flush_s  = 1'b1;
      req_vld_s    = 1'b0;
      ifid_vld_s   = 1'b0;
      ifid_instr_s = NOP;
      fetch_pc_s   = target_s;
      state_s      = S_RUN;
`ifdef FETCH_MISALIGN_CHK_EN
      // A bad target freezes the fetch address where it was.
      if (is_misaligned(bus.BrPC[1:0])) begin
        misalign_s = 1'b1;
        fetch_pc_s = fetch_pc_r;
        state_s    = S_HALT;
      end else begin
        misalign_s = misalign_r;
      end
`endif
    end else begin
      case (state_r)
        S_BOOT: begin
          if (!bus.Stall) begin
            req_pc_s   = fetch_pc_r;
            req_vld_s  = 1'b1;
            fetch_pc_s = fetch_pc_r + STEP;
            state_s    = S_RUN;
          end else begin
            state_s    = S_BOOT;
          end
        end
        S_RUN: begin
          if (!bus.Stall) begin
            ifid_pc_s    = req_pc_r;
            ifid_instr_s = req_vld_r ? bus.imem_rdata : NOP;
            ifid_vld_s   = req_vld_r;
            req_pc_s     = fetch_pc_r;
            req_vld_s    = 1'b1;
            fetch_pc_s   = fetch_pc_r + STEP;
          end else begin
            // The word in flight would be lost while memory re-reads fetch_pc.
            buf_capture_s = 1'b1;
            state_s       = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!bus.Stall) begin
            ifid_pc_s    = req_pc_r;
            ifid_instr_s = buf_vld_s ? buf_instr_s : NOP;
            ifid_vld_s   = buf_vld_s;
            req_pc_s     = fetch_pc_r;
            req_vld_s    = 1'b1;
            fetch_pc_s   = fetch_pc_r + STEP;
            state_s      = S_RUN;
          end else begin
            state_s      = S_HOLD;
          end
        end
        default: begin
          state_s = state_r;
        end
      endcase
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_BOOT;
      fetch_pc_r   <= {PC_W{1'b0}};
      req_pc_r     <= {PC_W{1'b0}};
      req_vld_r    <= 1'b0;
      ifid_pc_r    <= {PC_W{1'b0}};
      ifid_instr_r <= NOP;
      ifid_vld_r   <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_r   <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      fetch_pc_r   <= fetch_pc_s;
      req_pc_r     <= req_pc_s;
      req_vld_r    <= req_vld_s;
      ifid_pc_r    <= ifid_pc_s;
      ifid_instr_r <= ifid_instr_s;
      ifid_vld_r   <= ifid_vld_s;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_r   <= misalign_s;
`endif
    end
  end

  assign bus.imem_addr  = fetch_pc_r;
  assign bus.IfId_PC    = ifid_pc_r;
  assign bus.IfId_Instr = ifid_instr_r;
  assign bus.IfId_Valid = ifid_vld_r;
  assign bus.Flush      = bus.PcSel;
`ifdef FETCH_MISALIGN_CHK_EN
  assign bus.FetchMisalign = misalign_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: per-cycle expected IF/ID and fetch address from a spec model.
module tb_fetch_unit;

  localparam int PC_W    = 9;
  localparam int INSTR_W = 32;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic            vld;
    logic            chk_pc;
    logic [PC_W-1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] word(input logic [PC_W-1:0] a);
    return 32'hC0DE0000 | {23'd0, a};
  endfunction

  // Synchronous-read memory: word for the address presented last cycle.
  always @(posedge clk) bus.imem_rdata <= word(bus.imem_addr);

  function automatic exp_t mk(input logic [PC_W-1:0] pc, input logic vld, input logic [PC_W-1:0] addr);
    exp_t e;
    e.pc     = pc;
    e.vld    = vld;
    e.instr  = vld ? word(pc) : 32'h00000013;
    e.chk_pc = vld;
    e.addr   = addr;
    return e;
  endfunction

  // n = number of non-stalled edges since reset, no redirects.
  function automatic exp_t seq(input int n);
    return mk(PC_W'(4 * (n - 2)), n >= 2, PC_W'(4 * n));
  endfunction

  // j = edges since the redirect edge to target t, no stalls.
  function automatic exp_t redir(input int t, input int j);
    return mk(PC_W'(t + 4 * (j - 2)), j >= 2, PC_W'(t + 4 * j));
  endfunction

  task automatic drive(input logic st, input logic ps, input logic [31:0] br);
    bus.Stall = st;
    bus.PcSel = ps;
    bus.BrPC  = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    e = mk(9'h000, 1'b0, 9'h000);
    e.chk_pc = 1'b1;
    exp_q.push_back(e);
    tick();
    tick();
    e = exp_q.pop_front();
    checks++;
    if (bus.IfId_Valid !== e.vld || bus.IfId_Instr !== e.instr || bus.imem_addr !== e.addr || bus.IfId_PC !== e.pc) begin
      errors++;
      $display("FAIL reset: addr=%h pc=%h instr=%h vld=%b expected addr=%h pc=%h instr=%h vld=%b",
               bus.imem_addr, bus.IfId_PC, bus.IfId_Instr, bus.IfId_Valid, e.addr, e.pc, e.instr, e.vld);
    end
    checks++;
    if (bus.Flush !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush: got %b expected 0", bus.Flush);
    end
`ifdef FETCH_MISALIGN_CHK_EN
    checks++;
    if (bus.FetchMisalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_misalign: got %b expected 0", bus.FetchMisalign);
    end
`endif
    reset = 1'b0;
  endtask

  // 4 go, 3 stall (IF/ID at PC 8), then resume.
  task automatic test_stall_pc8();
    logic [11:0] pat;
    exp_t        e;
    int          n;
    pat = 12'b0000_0111_0000;
    n   = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(pat[i], 1'b0, 32'h0);
      if (!pat[i]) n++;
      exp_q.push_back(seq(n));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (bus.IfId_Valid !== e.vld || bus.IfId_Instr !== e.instr || bus.imem_addr !== e.addr || (e.chk_pc && bus.IfId_PC !== e.pc)) begin
        errors++;
        $display("FAIL stall_pc8 cyc%0d: addr=%h pc=%h instr=%h vld=%b expected addr=%h pc=%h instr=%h vld=%b",
                 i, bus.imem_addr, bus.IfId_PC, bus.IfId_Instr, bus.IfId_Valid, e.addr, e.pc, e.instr, e.vld);
      end
    end
  endtask

  // Random stalls including boot: stream is only delayed, never duplicated or dropped.
  task automatic test_random_stall();
    exp_t e;
    logic st;
    int   n;
    n = 0;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      st = (i < 2) ? 1'b1 : ($urandom_range(0, 2) == 0);
      drive(st, 1'b0, 32'h0);
      if (!st) n++;
      exp_q.push_back(seq(n));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (bus.IfId_Valid !== e.vld || bus.IfId_Instr !== e.instr || bus.imem_addr !== e.addr || (e.chk_pc && bus.IfId_PC !== e.pc)) begin
        errors++;
        $display("FAIL random_stall cyc%0d: addr=%h pc=%h instr=%h vld=%b expected addr=%h pc=%h instr=%h vld=%b",
                 i, bus.imem_addr, bus.IfId_PC, bus.IfId_Instr, bus.IfId_Valid, e.addr, e.pc, e.instr, e.vld);
      end
    end
  endtask

  // Redirect to 0x40 while IF/ID holds 0x10; also a wrap run to 0x1F8.
  task automatic test_redirect(input int target, input int pre, input int post);
    exp_t e;
    int   n;
    n = 0;
    do_reset();
    for (int i = 0; i < pre + post; i++) begin
      drive(1'b0, i == pre, 32'(target));
      if (i < pre) begin
        n++;
        exp_q.push_back(seq(n));
      end else begin
        exp_q.push_back(redir(target, i - pre));
      end
      #1;
      checks++;
      if (bus.Flush !== (i == pre)) begin
        errors++;
        $display("FAIL redirect_flush cyc%0d: got %b expected %b", i, bus.Flush, i == pre);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (bus.IfId_Valid !== e.vld || bus.IfId_Instr !== e.instr || bus.imem_addr !== e.addr || (e.chk_pc && bus.IfId_PC !== e.pc)) begin
        errors++;
        $display("FAIL redirect_%0h cyc%0d: addr=%h pc=%h instr=%h vld=%b expected addr=%h pc=%h instr=%h vld=%b",
                 target, i, bus.imem_addr, bus.IfId_PC, bus.IfId_Instr, bus.IfId_Valid, e.addr, e.pc, e.instr, e.vld);
      end
    end
  endtask

  // Redirect with Stall in S_HOLD: redirect wins and the buffered word is dropped.
  task automatic test_redirect_in_hold();
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) do_reset();
      if (i < 4) begin
        drive(1'b0, 1'b0, 32'h0);
        exp_q.push_back(seq(i + 1));
      end else if (i == 4) begin
        drive(1'b1, 1'b0, 32'h0);
        exp_q.push_back(seq(4));
      end else begin
        drive(i == 5, i == 5, 32'h80);
        exp_q.push_back(redir(32'h80, i - 5));
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (bus.IfId_Valid !== e.vld || bus.IfId_Instr !== e.instr || bus.imem_addr !== e.addr || (e.chk_pc && bus.IfId_PC !== e.pc)) begin
        errors++;
        $display("FAIL redirect_in_hold cyc%0d: addr=%h pc=%h instr=%h vld=%b expected addr=%h pc=%h instr=%h vld=%b",
                 i, bus.imem_addr, bus.IfId_PC, bus.IfId_Instr, bus.IfId_Valid, e.addr, e.pc, e.instr, e.vld);
      end
    end
  endtask

  // Misaligned target 0x42: trap when checked, otherwise aligned down to 0x40.
  task automatic test_misalign();
    exp_t e;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 3) begin
        drive(1'b0, 1'b0, 32'h0);
        exp_q.push_back(seq(i + 1));
      end else if (i == 3) begin
        drive(1'b0, 1'b1, 32'h42);
`ifdef FETCH_MISALIGN_CHK_EN
        exp_q.push_back(mk(9'h000, 1'b0, 9'h00C));
`else
        exp_q.push_back(redir(32'h40, 0));
`endif
      end else begin
`ifdef FETCH_MISALIGN_CHK_EN
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h80);
        exp_q.push_back(mk(9'h000, 1'b0, 9'h00C));
`else
        drive(1'b0, 1'b0, 32'h0);
        exp_q.push_back(redir(32'h40, i - 3));
`endif
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (bus.IfId_Valid !== e.vld || bus.IfId_Instr !== e.instr || bus.imem_addr !== e.addr || (e.chk_pc && bus.IfId_PC !== e.pc)) begin
        errors++;
        $display("FAIL misalign cyc%0d: addr=%h pc=%h instr=%h vld=%b expected addr=%h pc=%h instr=%h vld=%b",
                 i, bus.imem_addr, bus.IfId_PC, bus.IfId_Instr, bus.IfId_Valid, e.addr, e.pc, e.instr, e.vld);
      end
`ifdef FETCH_MISALIGN_CHK_EN
      checks++;
      if (bus.FetchMisalign !== (i >= 3)) begin
        errors++;
        $display("FAIL misalign_flag cyc%0d: got %b expected %b", i, bus.FetchMisalign, i >= 3);
      end
`endif
    end
  endtask

  // Reset asserted while in S_HOLD with a redirect pending: reset wins.
  task automatic test_reset_mid_stall();
    exp_t e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      reset = (i == 5);
      drive(i >= 4, i == 5, 32'h80);
      if (i < 4) begin
        exp_q.push_back(seq(i + 1));
      end else if (i == 4) begin
        exp_q.push_back(seq(4));
      end else begin
        e = mk(9'h000, 1'b0, 9'h000);
        e.chk_pc = 1'b1;
        exp_q.push_back(e);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (bus.IfId_Valid !== e.vld || bus.IfId_Instr !== e.instr || bus.imem_addr !== e.addr || (e.chk_pc && bus.IfId_PC !== e.pc)) begin
        errors++;
        $display("FAIL reset_mid_stall cyc%0d: addr=%h pc=%h instr=%h vld=%b expected addr=%h pc=%h instr=%h vld=%b",
                 i, bus.imem_addr, bus.IfId_PC, bus.IfId_Instr, bus.IfId_Valid, e.addr, e.pc, e.instr, e.vld);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    test_reset();
    test_stall_pc8();
    test_random_stall();
    test_redirect(32'h40, 6, 6);
    test_redirect(32'h1F8, 2, 7);
    test_redirect_in_hold();
    test_misalign();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end that consumes the execute-stage redirect (`PcSel`/`BrPC`) and owns the program counter. It drives a synchronous-read instruction memory (1-cycle latency) and loads the IF/ID pipeline register. It also absorbs hazard-unit stalls with a one-entry hold buffer and kills wrong-path instructions on a taken branch or jump.

## Interface
- `PC_W`, 9: width of the instruction address and all PC fields.
- `INSTR_W`, 32: instruction width.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `Stall`  in  1  hazard unit: hold PC and IF/ID.
- `PcSel`  in  1  execute stage: redirect request this cycle.
- `BrPC`  in  32  redirect target; bits [PC_W-1:0] used.
- `imem_addr`  out  PC_W  registered fetch address.
- `imem_rdata`  in  INSTR_W  word for the address presented last cycle.
- `IfId_PC`  out  PC_W  PC of the IF/ID instruction.
- `IfId_Instr`  out  INSTR_W  IF/ID instruction.
- `IfId_Valid`  out  1  IF/ID holds a real instruction.
- `Flush`  out  1  combinational `= PcSel`; clears ID/EX this cycle.
- `FetchMisalign`  out  1  sticky misaligned-target flag (`FETCH_MISALIGN_CHK_EN` only).

## Operation
- Registers:
  - `fetch_pc_q` drives `imem_addr`.
  - `req_pc_q`/`req_vld_q` track the address whose data arrives this cycle.
  - `buf_instr_q`/`buf_vld_q` form the hold buffer.
  - The IF/ID fields are the remaining state.
- Invalid IF/ID always carries `IfId_Instr = NOP` (32'h00000013).
- FSM states: `S_BOOT`, `S_RUN`, `S_HOLD`, `S_HALT`.
- `S_BOOT` (first cycle after reset):
  - Address 0 is presented and nothing is in flight.
  - If `Stall`=0: `req <= {0,1}`, `fetch_pc_q <= 4`, go to `S_RUN`.
  - If `Stall`=1: remain in `S_BOOT`.
- `S_RUN`, `Stall`=0:
  - IF/ID <= `{req_pc_q, imem_rdata, req_vld_q}`; the NOP substitution applies when `req_vld_q`=0.
  - `req <= {fetch_pc_q,1}`.
  - `fetch_pc_q += 4`.
- `S_RUN`, `Stall`=1:
  - IF/ID is held.
  - `buf <= {imem_rdata, req_vld_q}`.
  - `fetch_pc_q` is held; go to `S_HOLD`.
- `S_HOLD`, `Stall`=1: everything is held. Memory keeps re-reading `fetch_pc_q`, and that data is discarded.
- `S_HOLD`, `Stall`=0:
  - IF/ID <= `{req_pc_q, buf_instr_q, buf_vld_q}`.
  - `req <= {fetch_pc_q,1}`.
  - `fetch_pc_q += 4`; go to `S_RUN`.
- Redirect priority: `PcSel`=1 overrides `Stall` in every state except `S_HALT`. At the edge:
  - `fetch_pc_q <= BrPC[PC_W-1:0]`.
  - `req_vld_q`, `buf_vld_q` and `IfId_Valid` are cleared, and `IfId_Instr` becomes NOP.
  - State goes to `S_RUN`.
- PC arithmetic is unsigned PC_W-bit. `fetch_pc_q + 4` wraps modulo 2^PC_W with no flag. Bits [1:0] of `fetch_pc_q` are always 00.

## Timing
- Reset values:
  - `imem_addr`=0, `IfId_PC`=0, `IfId_Instr`=NOP, `IfId_Valid`=0, `FetchMisalign`=0.
  - State is `S_BOOT`.
- Sequential fetch: the instruction at address A appears in IF/ID two edges after A is on `imem_addr`. The first valid IF/ID (PC 0) appears 2 cycles after reset deasserts.
- Redirect penalty:
  - Target on `imem_addr` 1 edge after `PcSel`.
  - Target valid in IF/ID 3 edges after `PcSel`.
  - Exactly 2 NOP bubbles enter IF/ID.
- Stall: zero-loss. N stalled cycles delay the instruction stream by exactly N cycles, with no duplicate and no drop.
- Reset mid-stall or mid-redirect: reset wins. All state returns to reset values at that edge.

## Configuration
- `FETCH_MISALIGN_CHK_EN` defined:
  - Redirect with `PcSel`=1 and `BrPC[1:0]`≠0 sets `FetchMisalign` (sticky) and enters `S_HALT`.
  - In `S_HALT`: IF/ID is invalid (NOP), `imem_addr` is frozen, and inputs are ignored until `reset`.
- Undefined: the `FetchMisalign` port is absent, `S_HALT` is unreachable, and target bits [1:0] are forced to 00.

## Structure
- `fetch_pkg`:
  - `fetch_state_e` enum.
  - `NOP_INSTR` = 32'h00000013.
  - `PC_STEP` = 4.
- Sub-module `fetch_hold_buf`: one-entry capture/hold register with `buf_vld`, clear-on-flush, and synchronous reset.

## Test plan
- Reset, `Stall`=0, memory word = address: IF/ID PCs 0,4,8,… valid from cycle 2; `imem_addr` increments by 4 per cycle.
- Stall for 3 cycles while IF/ID holds PC 8: IF/ID stays at PC 8 for 4 cycles total, then PCs 12,16 follow with no gap and no repeat.
- `PcSel`=1, `BrPC`=0x40 while IF/ID holds PC 0x10: `Flush`=1 that cycle, 2 NOP bubbles, then IF/ID PC 0x40, 0x44.
- `PcSel`=1 and `Stall`=1 together in `S_HOLD`: redirect wins, buffer is dropped, and the target appears 3 edges later.
- PC_W=9, fetch reaches 0x1FC: next `imem_addr`=0x000 (wrap).
- With the macro, `BrPC`=0x42: `FetchMisalign`=1 and IF/ID remains NOP until reset. Without the macro, fetch proceeds from 0x40.
